// File: rtl/axi_default_slave_pkg.sv
// Shared AXI definitions for the default slave: response codes, width defaults
// and the write/read channel FSM state encodings.
package axi_default_slave_pkg;

  localparam int DEF_ID_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_default_slave_rd.sv
// Read-channel responder for the default slave: accepts one AR at a time and
// returns ARLEN+1 DECERR beats, holding each beat stable until RREADY.
module axi_default_slave_rd
  import axi_default_slave_pkg::*;
#(
  parameter int ID_WIDTH  = DEF_ID_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ID_WIDTH-1:0]  arid,
  input  logic [LEN_WIDTH-1:0] arlen,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [ID_WIDTH-1:0]  rid,
  output logic [1:0]           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready
);

  rd_state_e            state_q, state_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]  rid_q, rid_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    cnt_d     = cnt_q;
    case (state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          state_d   = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_DECERR;
          rid_d     = arid;
          cnt_d     = arlen;
          rlast_d   = (arlen == '0);
        end
      end
      R_DATA: begin
        if (rready && rvalid_q) begin
          if (rlast_q) begin
            state_d   = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OKAY;
          end else begin
            // rlast is precomputed so the counter stops at zero and never wraps
            cnt_d   = cnt_q - LEN_WIDTH'(1);
            rlast_d = (cnt_q == LEN_WIDTH'(1));
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: completes every burst to an unmapped address with DECERR.
// Define AXI_DEFSLV_ERRLOG_EN to add the err_addr/err_cnt/err_irq error log.
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
`ifdef AXI_DEFSLV_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [15:0]             err_cnt,
  output logic                    err_irq
`endif
);

  wr_state_e           wr_state_q, wr_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic                aw_hs, ar_hs;

  assign aw_hs = AWVALID && awready_q;
  assign ar_hs = ARVALID && ARREADY;

  // Write data is drained and dropped; only WLAST decides when the burst ends.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          wr_state_d = W_DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          bid_d      = AWID;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q && WLAST) begin
          wr_state_d = W_RESP;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_DECERR;
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          wr_state_d = W_IDLE;
          awready_d  = 1'b1;
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = bid_q;

  axi_default_slave_rd #(
    .ID_WIDTH  (ID_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_rd (
    .aclk    (ACLK),
    .aresetn (ARESETn),
    .arid    (ARID),
    .arlen   (ARLEN),
    .arvalid (ARVALID),
    .arready (ARREADY),
    .rid     (RID),
    .rresp   (RRESP),
    .rlast   (RLAST),
    .rvalid  (RVALID),
    .rready  (RREADY)
  );

  assign RDATA = '0;

  logic unused_inputs;
  assign unused_inputs = ^{WDATA, WSTRB, AWLEN};

`ifdef AXI_DEFSLV_ERRLOG_EN
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  err_irq_q, err_irq_d;
  logic [16:0]           err_sum;

  // AR address takes priority when both channels handshake together.
  always_comb begin
    err_addr_d = err_addr_q;
    if (ar_hs) begin
      err_addr_d = ARADDR;
    end else if (aw_hs) begin
      err_addr_d = AWADDR;
    end
    err_sum   = {1'b0, err_cnt_q} + 17'(aw_hs) + 17'(ar_hs);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    err_irq_d = aw_hs || ar_hs;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      err_irq_q  <= 1'b0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      err_irq_q  <= err_irq_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
  assign err_irq  = err_irq_q;
`else
  logic unused_addr;
  assign unused_addr = ^{AWADDR, ARADDR};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed table-driven bench for axi_default_slave, with hand-written
// sequences for reset, concurrency and mid-burst reset.
module tb_axi_default_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;
`ifdef AXI_DEFSLV_ERRLOG_EN
  logic [31:0] err_addr;
  logic [15:0] err_cnt;
  logic        err_irq;
  logic [15:0] cntBefore;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isRead;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    int          wBeats;
    int          stall;
    bit          toggle;
    int          expBeats;
    logic [1:0]  expResp;
  } vec_t;

  vec_t vecs[7];

  axi_default_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef AXI_DEFSLV_ERRLOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt), .err_irq(err_irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doWrite(input vec_t v);
    int n;
    n = 0;
    while (!AWREADY && n < 16) begin
      step();
      n++;
    end
    checkOutput("awready_idle", 64'(AWREADY), 64'd1);
    checkOutput("wready_idle", 64'(WREADY), 64'd0);
    AWVALID = 1'b1; AWID = v.id; AWADDR = v.addr; AWLEN = v.len;
    step();
    AWVALID = 1'b0;
    checkOutput("awready_drop", 64'(AWREADY), 64'd0);
    for (int b = 0; b < v.wBeats; b++) begin
      checkOutput("wready", 64'(WREADY), 64'd1);
      checkOutput("bvalid_early", 64'(BVALID), 64'd0);
      WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'hF; WLAST = (b == v.wBeats - 1);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    for (int s = 0; s <= v.stall; s++) begin
      BREADY = (s == v.stall);
      checkOutput("bvalid", 64'(BVALID), 64'd1);
      checkOutput("bid", 64'(BID), 64'(v.id));
      checkOutput("bresp", 64'(BRESP), 64'(v.expResp));
      step();
    end
    BREADY = 1'b0;
    checkOutput("bvalid_drop", 64'(BVALID), 64'd0);
    checkOutput("awready_back", 64'(AWREADY), 64'd1);
    step();
    checkOutput("bvalid_once", 64'(BVALID), 64'd0);
  endtask

  task automatic doRead(input vec_t v);
    int n;
    int beats;
    bit done;
    bit rr;
    n = 0;
    while (!ARREADY && n < 16) begin
      step();
      n++;
    end
    checkOutput("arready_idle", 64'(ARREADY), 64'd1);
    ARVALID = 1'b1; ARID = v.id; ARADDR = v.addr; ARLEN = v.len;
    step();
    ARVALID = 1'b0;
    checkOutput("arready_drop", 64'(ARREADY), 64'd0);
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      rr = v.toggle ? ((c % 2) == 1) : 1'b1;
      RREADY = rr;
      checkOutput("rvalid", 64'(RVALID), 64'd1);
      checkOutput("rid", 64'(RID), 64'(v.id));
      checkOutput("rdata", 64'(RDATA), 64'd0);
      checkOutput("rresp", 64'(RRESP), 64'(v.expResp));
      checkOutput("rlast", 64'(RLAST), 64'(beats == v.expBeats - 1));
      if (rr && RVALID) begin
        beats++;
        if (RLAST) done = 1'b1;
      end
      step();
    end
    RREADY = 1'b0;
    checkOutput("rd_beats", 64'(beats), 64'(v.expBeats));
    checkOutput("rvalid_drop", 64'(RVALID), 64'd0);
    checkOutput("arready_back", 64'(ARREADY), 64'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isRead) doRead(v);
    else          doWrite(v);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h12, 32'h3000_0000, 4'd0,  1, 0, 1'b0, 1,  2'b11};
    vecs[1] = '{1'b1, 8'h05, 32'h0000_2000, 4'd3,  0, 0, 1'b0, 4,  2'b11};
    vecs[2] = '{1'b1, 8'h3C, 32'h0000_2000, 4'd1,  0, 0, 1'b1, 2,  2'b11};
    vecs[3] = '{1'b0, 8'h7E, 32'h3000_0040, 4'd3,  4, 5, 1'b0, 1,  2'b11};
    vecs[4] = '{1'b0, 8'h44, 32'h3000_0080, 4'd3,  2, 1, 1'b0, 1,  2'b11};
    vecs[5] = '{1'b1, 8'hFF, 32'h0000_2100, 4'd15, 0, 0, 1'b0, 16, 2'b11};
    vecs[6] = '{1'b1, 8'h00, 32'h0000_2200, 4'd0,  0, 0, 1'b0, 1,  2'b11};

    ARESETn = 1'b0;
    AWID = 8'h00; AWADDR = '0; AWLEN = '0; AWVALID = 1'b1;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 8'h00; ARADDR = '0; ARLEN = '0; ARVALID = 1'b1; RREADY = 1'b0;
    repeat (3) step();
    checkOutput("rst_awready", 64'(AWREADY), 64'd0);
    checkOutput("rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("rst_outs", 64'({WREADY, BVALID, RVALID, RLAST, BID, RID, BRESP, RRESP}), 64'd0);
    checkOutput("rst_rdata", 64'(RDATA), 64'd0);
`ifdef AXI_DEFSLV_ERRLOG_EN
    checkOutput("rst_errlog", 64'({err_addr, err_cnt, err_irq}), 64'd0);
`endif
    ARESETn = 1'b1; AWVALID = 1'b0; ARVALID = 1'b0;
    step();
    checkOutput("post_rst_awready", 64'(AWREADY), 64'd1);
    checkOutput("post_rst_arready", 64'(ARREADY), 64'd1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Concurrent AW and AR in the same cycle
`ifdef AXI_DEFSLV_ERRLOG_EN
    cntBefore = err_cnt;
`endif
    checkOutput("cc_ready", 64'({AWREADY, ARREADY}), 64'd3);
    AWVALID = 1'b1; AWID = 8'hA1; AWADDR = 32'h3000_0000; AWLEN = 4'd0;
    ARVALID = 1'b1; ARID = 8'hB2; ARADDR = 32'h0000_2000; ARLEN = 4'd0;
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    checkOutput("cc_ready_drop", 64'({AWREADY, ARREADY}), 64'd0);
    checkOutput("cc_rvalid", 64'(RVALID), 64'd1);
    checkOutput("cc_rid", 64'(RID), 64'hB2);
    checkOutput("cc_rlast", 64'(RLAST), 64'd1);
    checkOutput("cc_wready", 64'(WREADY), 64'd1);
`ifdef AXI_DEFSLV_ERRLOG_EN
    checkOutput("cc_err_cnt", 64'(err_cnt), 64'(cntBefore + 16'd2));
    checkOutput("cc_err_addr", 64'(err_addr), 64'h0000_2000);
    checkOutput("cc_err_irq", 64'(err_irq), 64'd1);
`endif
    RREADY = 1'b1; WVALID = 1'b1; WLAST = 1'b1;
    step();
    RREADY = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    checkOutput("cc_rvalid_drop", 64'(RVALID), 64'd0);
    checkOutput("cc_arready", 64'(ARREADY), 64'd1);
    checkOutput("cc_bvalid", 64'(BVALID), 64'd1);
    checkOutput("cc_bid", 64'(BID), 64'hA1);
    checkOutput("cc_bresp", 64'(BRESP), 64'd3);
`ifdef AXI_DEFSLV_ERRLOG_EN
    checkOutput("cc_err_irq_pulse", 64'(err_irq), 64'd0);
`endif
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    checkOutput("cc_bvalid_drop", 64'(BVALID), 64'd0);
    checkOutput("cc_awready", 64'(AWREADY), 64'd1);

    // Reset in the middle of an 8-beat read burst
    ARVALID = 1'b1; ARID = 8'h5A; ARADDR = 32'h0000_2000; ARLEN = 4'd7;
    step();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int b = 0; b < 3; b++) begin
      checkOutput("mr_rvalid", 64'(RVALID), 64'd1);
      checkOutput("mr_rlast", 64'(RLAST), 64'd0);
      step();
    end
    ARESETn = 1'b0; RREADY = 1'b0;
    step();
    checkOutput("mr_rvalid_drop", 64'(RVALID), 64'd0);
    checkOutput("mr_arready", 64'(ARREADY), 64'd0);
    ARESETn = 1'b1;
    step();
    checkOutput("mr_arready_back", 64'(ARREADY), 64'd1);
    checkOutput("mr_no_resp", 64'({RVALID, BVALID}), 64'd0);
    applyStimulus(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
